timer_cmd_tx: RTL
=================

// Module: timer_cmd_tx
// PURPOSE
//  Host-side initiator for the serial timer-start protocol. Accepts a 4-bit delay
//  command and emits the start pattern 1101 on `data`, followed by the delay (MSB first).
//  It then waits for the timer FSM's `done` and answers with a one-cycle `ack`.
//  Sits between the command scheduler and the timer FSM, driving that FSM's data/ack inputs.
// PARAMETERS
//  GAP_CYCLES      2     idle zeros on data after ack/reset before next accept (>=1)
//  CNT_W           16    width of resp_cycles wait counter
//  TIMEOUT_CYCLES  4096  WAIT cycles before abort (used only with TIMER_TX_TIMEOUT_EN)
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  areset_n      in   1      asynchronous active-low reset
//  cmd_valid     in   1      command request
//  cmd_delay     in   4      delay value to transmit
//  cmd_ready     out  1      1 only in IDLE; accept = cmd_valid & cmd_ready
//  data          out  1      serial line to timer FSM (registered)
//  done          in   1      timer FSM done indication
//  ack           out  1      acknowledge to timer FSM (registered, 1-cycle pulse)
//  resp_valid    out  1      1-cycle pulse: command finished
//  resp_timeout  out  1      with resp_valid: 1 = aborted by timeout
//  resp_cycles   out  CNT_W  WAIT cycles incl. the done cycle; saturates at 2^CNT_W-1
// BEHAVIOUR
//  States: GAP, IDLE, PAT, DLY, WAIT, ACK. Registered shift reg sh[7:0], idx[1:0].
//  - Reset (async assert, sync release): state=GAP, gap count=GAP_CYCLES.
//    data=0, ack=0, resp_valid=0, resp_timeout=0, resp_cycles=0, cmd_ready=0.
//  - GAP: data=0; after GAP_CYCLES cycles -> IDLE. Guarantees the timer FSM is in pattern search.
//  - IDLE: cmd_ready=1, data=0. On accept: load sh={4'b1101,cmd_delay} and clear the wait counter.
//    At that same edge data<=sh[7]=1 and state -> PAT.
//  - PAT/DLY: data shifts out one bit per cycle, MSB first, 8 consecutive cycles total.
//    Order: 1,1,0,1 (PAT), then delay[3..0] (DLY). No gaps.
//    First pattern bit appears on data in the cycle after accept.
//  - WAIT: data=0. Each cycle the counter increments, saturating.
//    done is sampled only here; done=1 -> ACK. done seen in any other state is ignored.
//  - ACK: ack=1 for exactly one cycle, with resp_valid=1, resp_timeout=0, resp_cycles=final count.
//    Then -> GAP. resp_cycles holds its value until the next resp_valid.
//  - Accept-to-WAIT-entry latency: 9 edges. done-to-ack latency: 1 edge.
//  - cmd_valid outside IDLE is ignored (no queueing); cmd_delay is sampled only at accept.
//  - Reset mid-command aborts immediately: data/ack forced 0 and no resp_valid.
//    After release: GAP, then IDLE.
// CONFIGURATION
//  TIMER_TX_TIMEOUT_EN defined: if WAIT lasts TIMEOUT_CYCLES cycles without done,
//    the FSM pulses resp_valid=1 with resp_timeout=1 and resp_cycles=TIMEOUT_CYCLES.
//    ack stays 0 and the FSM goes to GAP.
//    If done=1 in the cycle the limit is reached, done wins (normal ACK).
//  Not defined: WAIT persists until done or reset; resp_timeout is tied 0.
// TESTING
//  1 areset_n low 3 cycles, release -> data=0, cmd_ready=0 for 2 cycles, then cmd_ready=1.
//  2 accept cmd_delay=4'b1001 -> data on next 8 cycles =1,1,0,1,1,0,0,1, then 0.
//    Paired timer FSM shift_ena high exactly during the last 4 of those cycles.
//  3 done raised in 5th WAIT cycle -> ack=1 for one cycle in the next cycle.
//    resp_valid=1, resp_cycles=5, resp_timeout=0; cmd_ready=1 two cycles after ack.
//  4 cmd_valid=1 held with delay=4'hF throughout a command -> exactly one accept per IDLE visit.
//    done pulses in PAT/DLY produce no ack.
//  5 areset_n low during 2nd DLY bit -> data=0, ack=0 immediately; no resp_valid.
//    After release: 2-cycle GAP, then IDLE.
//  6 TIMER_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never -> resp_valid=1, resp_timeout=1, resp_cycles=16, ack=0.
//    Without the macro: remains in WAIT, cmd_ready=0 after 100 cycles.

Source files
------------

// File: rtl/timer_cmd_tx.sv
// rtl/timer_cmd_tx.sv - host-side initiator for the serial timer-start protocol
//
// Accepts a 4-bit delay command, sends the start pattern 1101 followed by the
// delay (MSB first) on data, waits for the timer FSM's done and answers with
// a one-cycle ack, then reports the wait time on resp_cycles.
//
// Optional feature macro: TIMER_TX_TIMEOUT_EN (abort WAIT after TIMEOUT_CYCLES).
//
// Ports:
//   clk           in   1      clock, rising edge
//   areset_n      in   1      asynchronous active-low reset
//   cmd_valid     in   1      command request
//   cmd_delay     in   4      delay value to transmit
//   cmd_ready     out  1      high only in IDLE
//   data          out  1      registered serial line to the timer FSM
//   done          in   1      timer FSM done (sampled in WAIT only)
//   ack           out  1      registered one-cycle acknowledge
//   resp_valid    out  1      one-cycle pulse: command finished
//   resp_timeout  out  1      with resp_valid: command aborted by timeout
//   resp_cycles   out  CNT_W  WAIT cycles including the done cycle, saturating

module timer_cmd_tx #(
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_delay,
    output logic             cmd_ready,
    output logic             data,
    input  logic             done,
    output logic             ack,
    output logic             resp_valid,
    output logic             resp_timeout,
    output logic [CNT_W-1:0] resp_cycles
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_GAP,
        S_IDLE,
        S_PAT,
        S_DLY,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ack_q, ack_d;
    logic               rv_q, rv_d;
    logic               rt_q, rt_d;
    logic [CNT_W-1:0]   rc_q, rc_d;

    // The shift register's MSB is the serial line itself: zeros shift in
    // behind the 8 command bits, so sh_q is all-zero whenever no command is
    // being sent and data is low outside PAT/DLY without extra gating.
    assign data         = sh_q[7];
    assign cmd_ready    = (state_q == S_IDLE);
    assign ack          = ack_q;
    assign resp_valid   = rv_q;
    assign resp_timeout = rt_q;
    assign resp_cycles  = rc_q;

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_GAP;
            gap_q   <= GAP_W'(GAP_CYCLES);
            idx_q   <= 2'd0;
            sh_q    <= 8'd0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rv_q    <= 1'b0;
            rt_q    <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rt_q    <= rt_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        sh_d    = {sh_q[6:0], 1'b0};
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        rv_d    = 1'b0;
        rt_d    = rt_q;
        rc_d    = rc_q;
        case (state_q)
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    sh_d    = {4'b1101, cmd_delay};
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = S_PAT;
                end
            end
            S_PAT: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DLY;
                end
            end
            S_DLY: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (done) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rv_d    = 1'b1;
                    rt_d    = 1'b0;
                    rc_d    = cnt_inc;
                end
`ifdef TIMER_TX_TIMEOUT_EN
                // done on the limit cycle takes the normal ACK path above.
                else if (32'(cnt_inc) == 32'(TIMEOUT_CYCLES)) begin
                    state_d = S_GAP;
                    gap_d   = GAP_W'(GAP_CYCLES);
                    rv_d    = 1'b1;
                    rt_d    = 1'b1;
                    rc_d    = cnt_inc;
                end
`endif
            end
            S_ACK: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(GAP_CYCLES);
            end
            default: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(GAP_CYCLES);
            end
        endcase
    end

endmodule
